// File: rtl/enigma_rotor_ctrl.sv
// enigma_rotor_ctrl: owns the three rotor positions, applies Enigma stepping
// (including the middle-rotor double step) and walks one shared lookup
// datapath through the seven substitutions of a character.
module enigma_rotor_ctrl #(
  parameter logic [4:0] NOTCH_R = 5'd21,
  parameter logic [4:0] NOTCH_M = 5'd4,
  parameter logic [4:0] NOTCH_L = 5'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [4:0] load_l,
  input  logic [4:0] load_m,
  input  logic [4:0] load_r,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] data_in,
  output logic [2:0] lk_stage,
  output logic [4:0] lk_data,
  output logic [4:0] lk_position,
  input  logic [4:0] lk_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] data_out,
  output logic       err_out,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic       notch_l_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_PASS = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] LAST_LETTER = 5'd25;
  localparam logic [2:0] LAST_STAGE  = 3'd6;

  state_t     state_reg, state_next;
  logic [2:0] sc_reg, sc_next;
  logic [4:0] w_reg, w_next;
  logic [4:0] pos_l_reg, pos_l_next;
  logic [4:0] pos_m_reg, pos_m_next;
  logic [4:0] pos_r_reg, pos_r_next;
  logic [4:0] data_out_reg, data_out_next;
  logic       err_reg, err_next;

  // Advance one rotor position, wrapping Z back to A.
  function automatic logic [4:0] step_pos(input logic [4:0] p);
    return (p == LAST_LETTER) ? 5'd0 : p + 5'd1;
  endfunction

  // Out-of-range load values fall back to position 0 so positions stay in 0..25.
  function automatic logic [4:0] clamp_pos(input logic [4:0] p);
    return (p > LAST_LETTER) ? 5'd0 : p;
  endfunction

  // State and datapath registers; reset discards any in-flight character.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      sc_reg       <= 3'd0;
      w_reg        <= 5'd0;
      pos_l_reg    <= 5'd0;
      pos_m_reg    <= 5'd0;
      pos_r_reg    <= 5'd0;
      data_out_reg <= 5'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sc_reg       <= sc_next;
      w_reg        <= w_next;
      pos_l_reg    <= pos_l_next;
      pos_m_reg    <= pos_m_next;
      pos_r_reg    <= pos_r_next;
      data_out_reg <= data_out_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic: load/accept in IDLE, stepping, seven-stage pass, result hold.
  always_comb begin
    state_next    = state_reg;
    sc_next       = sc_reg;
    w_next        = w_reg;
    pos_l_next    = pos_l_reg;
    pos_m_next    = pos_m_reg;
    pos_r_next    = pos_r_reg;
    data_out_next = data_out_reg;
    err_next      = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load_en) begin
          pos_l_next = clamp_pos(load_l);
          pos_m_next = clamp_pos(load_m);
          pos_r_next = clamp_pos(load_r);
        end else if (in_valid) begin
          w_next = data_in;
          if (data_in > LAST_LETTER) begin
            // Not a letter: report it unchanged and leave the rotors alone.
            data_out_next = data_in;
            err_next      = 1'b1;
            state_next    = ST_DONE;
          end else begin
            state_next = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        // All decisions use the pre-step positions; the middle rotor
        // stepping on its own notch is the double step.
        pos_r_next = step_pos(pos_r_reg);
        if ((pos_r_reg == NOTCH_R) || (pos_m_reg == NOTCH_M)) begin
          pos_m_next = step_pos(pos_m_reg);
        end
        if (pos_m_reg == NOTCH_M) begin
          pos_l_next = step_pos(pos_l_reg);
        end
        sc_next    = 3'd0;
        state_next = ST_PASS;
      end
      ST_PASS: begin
        w_next  = lk_result;
        sc_next = sc_reg + 3'd1;
        if (sc_reg == LAST_STAGE) begin
          sc_next       = 3'd0;
          data_out_next = lk_result;
          err_next      = 1'b0;
          state_next    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Lookup drive: stage select, working letter and the rotor position for that stage.
  always_comb begin
    lk_stage    = 3'd0;
    lk_data     = 5'd0;
    lk_position = 5'd0;
    if (state_reg == ST_PASS) begin
      lk_stage = sc_reg;
      lk_data  = w_reg;
      case (sc_reg)
        3'd0, 3'd6: lk_position = pos_r_reg;
        3'd1, 3'd5: lk_position = pos_m_reg;
        3'd2, 3'd4: lk_position = pos_l_reg;
        default:    lk_position = 5'd0;
      endcase
    end
  end

  // Handshake and status outputs.
  always_comb begin
    in_ready    = (state_reg == ST_IDLE) && !load_en;
    out_valid   = (state_reg == ST_DONE);
    data_out    = data_out_reg;
    err_out     = err_reg;
    pos_l       = pos_l_reg;
    pos_m       = pos_m_reg;
    pos_r       = pos_r_reg;
    notch_l_out = (pos_l_reg == NOTCH_L);
  end

endmodule

// File: tb/tb_enigma_rotor_ctrl.sv
// tb_enigma_rotor_ctrl: scoreboard bench. Stimulus pushes expected results
// computed by an Enigma reference model; a monitor pops and compares them
// when the DUT presents out_valid.
module tb_enigma_rotor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic [4:0] load_l, load_m, load_r;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] data_in;
  logic [2:0] lk_stage;
  logic [4:0] lk_data;
  logic [4:0] lk_position;
  logic [4:0] lk_result;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] data_out;
  logic       err_out;
  logic [4:0] pos_l, pos_m, pos_r;
  logic       notch_l_out;

  enigma_rotor_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en),
    .load_l(load_l), .load_m(load_m), .load_r(load_r),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .lk_stage(lk_stage), .lk_data(lk_data), .lk_position(lk_position),
    .lk_result(lk_result), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_out(err_out),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r), .notch_l_out(notch_l_out)
  );

  always #5 clk = ~clk;

  // Rotor wirings I (left), II (middle), III (right) and reflector B.
  int rot_f[3][26];
  int rot_b[3][26];
  int refl[26];

  initial begin
    string s;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
      else if (r == 1) s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
      else s = "BDFHJLCPRTXVZNYEOWUGAIMQSK";
      for (int i = 0; i < 26; i++) begin
        rot_f[r][i] = int'(s[i]) - 65;
        rot_b[r][rot_f[r][i]] = i;
      end
    end
    s = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    for (int i = 0; i < 26; i++) refl[i] = int'(s[i]) - 65;
  end

  // One substitution: stages 0-2 forward R/M/L, 3 reflector, 4-6 backward L/M/R.
  function automatic int subst(int s, int c, int p);
    int rot, e, o;
    c = c % 26;
    p = p % 26;
    if (s == 3) return refl[c];
    if (s > 6) return 0;
    rot = (s == 0 || s == 6) ? 2 : ((s == 1 || s == 5) ? 1 : 0);
    e = (c + p) % 26;
    o = (s < 3) ? rot_f[rot][e] : rot_b[rot][e];
    return (o - p + 26) % 26;
  endfunction

  always_comb lk_result = 5'(subst(int'(lk_stage), int'(lk_data), int'(lk_position)));

  // Reference model state: rotor positions as letters 0..25.
  int ml, mm, mr;

  typedef struct {
    int d;
    int e;
    int l;
    int m;
    int r;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hold_req = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit mid_turn, left_turn;
    mid_turn  = (mr == 21) || (mm == 4);
    left_turn = (mm == 4);
    mr = (mr + 1) % 26;
    if (mid_turn) mm = (mm + 1) % 26;
    if (left_turn) ml = (ml + 1) % 26;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic do_load(input int l, input int m, input int r);
    wait_ready();
    load_en = 1'b1;
    load_l = 5'(l);
    load_m = 5'(m);
    load_r = 5'(r);
    #1;
    check("in_ready_during_load", int'(in_ready), 0);
    @(posedge clk);
    #1;
    load_en = 1'b0;
    ml = (l > 25) ? 0 : l;
    mm = (m > 25) ? 0 : m;
    mr = (r > 25) ? 0 : r;
    check("load_pos_l", int'(pos_l), ml);
    check("load_pos_m", int'(pos_m), mm);
    check("load_pos_r", int'(pos_r), mr);
    check("load_notch_l", int'(notch_l_out), int'(ml == 16));
    $display("load L=%0d M=%0d R=%0d -> %0d/%0d/%0d", l, m, r, pos_l, pos_m, pos_r);
  endtask

  // Send one character; abort=1 resets the DUT in the middle of the pass.
  task automatic send(input int c, input bit abort);
    int v[8];
    int epos[7];
    exp_t e;
    wait_ready();
    in_valid = 1'b1;
    data_in  = 5'(c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (c > 25) begin
      e = '{d: c, e: 1, l: ml, m: mm, r: mr};
      sb.push_back(e);
      check("err_out_valid_latency", int'(out_valid), 1);
      $display("send %0d (out of range) expect err", c);
      return;
    end
    model_step();
    v[0] = c;
    v[1] = subst(0, v[0], mr);
    v[2] = subst(1, v[1], mm);
    v[3] = subst(2, v[2], ml);
    v[4] = subst(3, v[3], 0);
    v[5] = subst(4, v[4], ml);
    v[6] = subst(5, v[5], mm);
    v[7] = subst(6, v[6], mr);
    epos = '{mr, mm, ml, 0, ml, mm, mr};
    if (!abort) begin
      e = '{d: v[7], e: 0, l: ml, m: mm, r: mr};
      sb.push_back(e);
    end
    $display("send %0d pos %0d/%0d/%0d expect %0d%s", c, ml, mm, mr, v[7], abort ? " (aborted)" : "");
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (n < 8) begin
        check("lk_stage", int'(lk_stage), n - 1);
        check("lk_data", int'(lk_data), v[n-1]);
        check("lk_position", int'(lk_position), epos[n-1]);
        check("in_ready_busy", int'(in_ready), 0);
        check("out_valid_early", int'(out_valid), 0);
      end else begin
        check("out_valid_latency8", int'(out_valid), 1);
      end
      if (abort && n == 2) begin
        load_en = 1'b1;
        load_l = 5'd7;
        load_m = 5'd7;
        load_r = 5'd7;
      end
      if (abort && n == 3) begin
        load_en = 1'b0;
        check("load_ignored_l", int'(pos_l), ml);
        check("load_ignored_m", int'(pos_m), mm);
        check("load_ignored_r", int'(pos_r), mr);
      end
      if (abort && n == 4) begin
        rst_n = 1'b0;
        #1;
        ml = 0;
        mm = 0;
        mr = 0;
        check("abort_pos_l", int'(pos_l), 0);
        check("abort_pos_m", int'(pos_m), 0);
        check("abort_pos_r", int'(pos_r), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_lk_stage", int'(lk_stage), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (out_valid) check("abort_no_output", int'(out_valid), 0);
        end
        check("abort_in_ready_after", int'(in_ready), 1);
        return;
      end
    end
  endtask

  // Monitor: pops and compares on each new result, checks stability while held.
  initial begin
    bit   seen;
    int   hold_left;
    logic [4:0] held_d;
    logic held_e;
    exp_t e;
    seen = 1'b0;
    hold_left = 0;
    held_d = '0;
    held_e = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            check("unexpected_output", int'(out_valid), 0);
          end else begin
            e = sb.pop_front();
            check("data_out", int'(data_out), e.d);
            check("err_out", int'(err_out), e.e);
            check("res_pos_l", int'(pos_l), e.l);
            check("res_pos_m", int'(pos_m), e.m);
            check("res_pos_r", int'(pos_r), e.r);
            check("res_notch_l", int'(notch_l_out), int'(e.l == 16));
            $display("result data_out=%0d err=%0d pos %0d/%0d/%0d", data_out, err_out, pos_l, pos_m, pos_r);
          end
          seen = 1'b1;
          held_d = data_out;
          held_e = err_out;
          hold_left = hold_req;
        end else begin
          check("hold_data_out", int'(data_out), int'(held_d));
          check("hold_err_out", int'(err_out), int'(held_e));
          check("hold_in_ready", int'(in_ready), 0);
        end
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_ready) seen = 1'b0;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n = 1'b0;
    load_en = 1'b0;
    load_l = '0;
    load_m = '0;
    load_r = '0;
    in_valid = 1'b0;
    data_in = '0;
    ml = 0;
    mm = 0;
    mr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_err_out", int'(err_out), 0);
    check("rst_pos_l", int'(pos_l), 0);
    check("rst_pos_m", int'(pos_m), 0);
    check("rst_pos_r", int'(pos_r), 0);
    check("rst_notch_l", int'(notch_l_out), 0);
    check("rst_lk_stage", int'(lk_stage), 0);
    check("rst_lk_data", int'(lk_data), 0);
    check("rst_lk_position", int'(lk_position), 0);

    send(0, 1'b0);                  // A from 0/0/0
    do_load(0, 0, 21);  send(1, 1'b0);
    do_load(0, 4, 5);   send(2, 1'b0);  send(3, 1'b0);
    do_load(25, 4, 25); send(4, 1'b0);
    do_load(16, 3, 30);
    hold_req = 5;
    send(5, 1'b0);
    wait_ready();
    hold_req = 0;
    send(27, 1'b0);
    send(31, 1'b0);
    do_load(2, 4, 20);
    send(6, 1'b1);                  // reset at sc=3

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      else if (r == 1) do_load(16, 4, 21);
      else if (r == 2) send($urandom_range(26, 31), 1'b0);
      else send($urandom_range(0, 25), 1'b0);
    end

    wait_ready();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_ctrl.md
# enigma_rotor_ctrl

Sequencer for the cipher path. It owns the three rotor positions and applies Enigma stepping, including the middle-rotor double step. It then drives a single shared lookup datapath through the seven substitutions of one character: forward right/middle/left, reflector, then backward left/middle/right. It sits between the keyboard/UART character source and the output display logic, and replaces the free-running combinational rotor chain with one time-multiplexed lookup.

## Interface
- NOTCH_R, 21: right-rotor turnover position (V).
- NOTCH_M, 4: middle-rotor turnover position (E).
- NOTCH_L, 16: left-rotor turnover position (Q); reported only, the left rotor drives nothing.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_en  in  1  load starting positions; honoured only in IDLE.
- load_l, load_m, load_r  in  5 each  starting positions 0..25; values above 25 load as 0.
- in_valid  in  1  character request.
- in_ready  out  1  high in IDLE when load_en is low.
- data_in  in  5  letter 0..25.
- lk_stage  out  3  lookup select: 0=R fwd, 1=M fwd, 2=L fwd, 3=reflector, 4=L bwd, 5=M bwd, 6=R bwd.
- lk_data  out  5  letter presented to the lookup.
- lk_position  out  5  rotor position for the stage; 0 for the reflector.
- lk_result  in  5  combinational lookup result, valid in the same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- data_out  out  5  enciphered letter.
- err_out  out  1  qualifies data_out; high when data_in was out of range.
- pos_l, pos_m, pos_r  out  5 each  current positions.
- notch_l_out  out  1  high when pos_l equals NOTCH_L.

## Operation
- States: IDLE, STEP, PASS, DONE, plus a 3-bit stage counter sc used in PASS.
- IDLE:
  - load_en has priority over in_valid. A load copies the positions; the state stays IDLE.
  - Accept when in_valid && in_ready. The accept latches data_in into working register w.
  - If data_in > 25: go straight to DONE with data_out=data_in and err_out=1. No stepping.
  - Otherwise go to STEP.
- STEP: uses the pre-step positions.
  - The right rotor always steps.
  - The middle rotor steps if pos_r==NOTCH_R or pos_m==NOTCH_M (double step).
  - The left rotor steps if pos_m==NOTCH_M.
  - Step arithmetic is (p==25)?0:p+1. Positions never hold 26..31.
  - Then go to PASS with sc=0.
- PASS:
  - Drive lk_stage=sc and lk_data=w.
  - lk_position is pos_r, pos_m, pos_l, 0, pos_l, pos_m, pos_r for sc=0..6.
  - Each cycle, w <= lk_result and sc increments.
  - When sc==6, w is captured, the state moves to DONE and data_out takes the stage-6 result.
- DONE:
  - out_valid=1; data_out and err_out are held stable.
  - Leave to IDLE on out_valid && out_ready.
- lk_* outputs are 0 outside PASS.
- load_en outside IDLE is ignored.
- in_valid outside IDLE is not accepted and is not queued.

## Timing
- Reset values:
  - state IDLE, sc 0, w 0.
  - in_ready 1 after reset, while load_en is low.
  - out_valid 0, data_out 0, err_out 0.
  - pos_l, pos_m, pos_r 0; notch_l_out 0.
  - lk_stage, lk_data, lk_position 0.
- Accept on edge k:
  - Positions update at edge k+1.
  - PASS runs in the cycles after edges k+1..k+7.
  - out_valid rises after edge k+8, so latency is 8 cycles.
  - With out_ready high, the next accept is possible at edge k+10.
- Error path: out_valid rises after edge k.
- out_ready low holds DONE indefinitely with outputs unchanged.
- in_ready is low in STEP, PASS and DONE.
- rst_n low at any point (mid-PASS included): immediate return to the reset values above. The in-flight character is discarded and not reported.

## Test plan
- Reset, positions 0/0/0, send 0 (A). Expect:
  - After the accept, lk_stage 0..6 on consecutive cycles.
  - lk_position 1,0,0,0,0,0,1 during PASS.
  - out_valid exactly 8 cycles after the accept; pos_r=1.
- Load L=0, M=0, R=21, send one char. Expect pos_l=0, pos_m=1, pos_r=22.
- Double step: load L=0, M=4, R=5, send one char. Expect pos_l=1, pos_m=5, pos_r=6. A second char gives 1/5/7.
- Wrap: load L=25, M=4, R=25, send one char. Expect pos_l=0, pos_m=5, pos_r=0. Load R=30: expect pos_r=0.
- Backpressure and range:
  - Hold out_ready=0 for 5 cycles in DONE. data_out is stable and in_ready stays 0.
  - Send data_in=27. Expect err_out=1, data_out=27, positions unchanged, out_valid 1 cycle after the accept.
- Assert rst_n low at PASS sc=3. Expect out_valid never rises, all positions 0 and in_ready 1 after release. A load_en pulse asserted during PASS has no effect.
